// File: rtl/tc_multi.sv
// tc_multi: NCH-channel MMIO down-counter with per-channel prescaler, one-shot/auto-reload and W1C ISR.
// Optional cascade mode (channel c counts channel c-1 terminal events) is built only with `define TC_CASCADE_EN.
module tc_multi #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  localparam logic [4:0] ISR_IDX = 5'(4 * NCH);

  logic [4:0]     idx;
  logic           isr_wr;
  logic [NCH-1:0] isr_q;
  logic [NCH-1:0] term;
  logic [NCH-1:0] im_vec;
  logic [31:0]    ch_rd [NCH];
  logic           unused_bits;

  assign idx         = Addr[6:2];
  assign isr_wr      = WE && (idx == ISR_IDX);
  assign unused_bits = ^{Addr[31:7], Din};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e           state_q;
    logic             en_q, im_q;
    logic [1:0]       mode_q;
    logic [PSC_W-1:0] psc_q, pcnt_q;
    logic [CNT_W-1:0] preset_q, count_q;
    logic             wr_sel, wr_ctrl, wr_preset, wr_count;
    logic             tick, cnt_le1, term_c, cas;
    logic [31:0]      ctrl_w;

    assign wr_sel    = WE && (idx[4:2] == 3'(c)) && (idx[1:0] != 2'd3);
    assign wr_ctrl   = wr_sel && (idx[1:0] == 2'd0);
    assign wr_preset = wr_sel && (idx[1:0] == 2'd1);
    assign wr_count  = wr_sel && (idx[1:0] == 2'd2);
    assign cnt_le1   = (count_q <= CNT_W'(1));

`ifdef TC_CASCADE_EN
    if (c > 0) begin : g_cas
      logic cas_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cas_q <= 1'b0;
        else if (wr_ctrl) cas_q <= Din[4];
      end
      assign cas  = cas_q;
      assign tick = cas_q ? g_ch[c-1].term_c : (pcnt_q == psc_q);
    end else begin : g_nocas
      assign cas  = 1'b0;
      assign tick = (pcnt_q == psc_q);
    end
`else
    assign cas  = 1'b0;
    assign tick = (pcnt_q == psc_q);
`endif

    // Terminal event: the cycle in which this channel sets its ISR bit.
    assign term_c = !wr_sel && (state_q == S_CNT) && en_q && tick && cnt_le1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= S_IDLE;
        en_q     <= 1'b0;
        im_q     <= 1'b0;
        mode_q   <= 2'b00;
        psc_q    <= '0;
        pcnt_q   <= '0;
        preset_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_preset) preset_q <= Din[CNT_W-1:0];
        if (wr_sel) begin
          // A bus write owns the channel this cycle: FSM, COUNT and prescaler hold.
          if (wr_ctrl) begin
            en_q   <= Din[0];
            mode_q <= Din[2:1];
            im_q   <= Din[3];
            psc_q  <= Din[8 +: PSC_W];
          end
          if (wr_count) count_q <= Din[CNT_W-1:0];
        end else begin
          unique case (state_q)
            S_IDLE: begin
              if (en_q) begin
                pcnt_q  <= '0;
                state_q <= S_LOAD;
              end
            end
            S_LOAD: begin
              count_q <= preset_q;
              state_q <= S_CNT;
            end
            S_CNT: begin
              if (!en_q) begin
                state_q <= S_IDLE;
              end else begin
                pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
                if (tick) begin
                  if (!cnt_le1) begin
                    count_q <= count_q - 1'b1;
                  end else begin
                    count_q <= '0;
                    state_q <= S_INT;
                  end
                end
              end
            end
            S_INT: begin
              if (mode_q == 2'b00) begin
                en_q    <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                pcnt_q  <= '0;
                state_q <= S_LOAD;
              end
            end
          endcase
        end
      end
    end

    // NOTE: the zero default before field packing keeps this combinational block latch-free.
    always_comb begin
      ctrl_w              = '0;
      ctrl_w[0]           = en_q;
      ctrl_w[2:1]         = mode_q;
      ctrl_w[3]           = im_q;
      ctrl_w[4]           = cas;
      ctrl_w[8 +: PSC_W]  = psc_q;
    end

    assign ch_rd[c]  = (idx[1:0] == 2'd0) ? ctrl_w :
                       (idx[1:0] == 2'd1) ? 32'(preset_q) :
                       (idx[1:0] == 2'd2) ? 32'(count_q) : 32'd0;
    assign term[c]   = term_c;
    assign im_vec[c] = im_q;
  end

  // A terminal event and a W1C on the same bit in one cycle leaves the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) isr_q <= '0;
    else        isr_q <= (isr_q & ~(isr_wr ? Din[NCH-1:0] : {NCH{1'b0}})) | term;
  end

  assign IRQ = |(isr_q & im_vec);

  always_comb begin
    Dout = '0;
    if (idx == ISR_IDX) begin
      Dout[NCH-1:0] = isr_q;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (idx[4:2] == 3'(c)) Dout = ch_rd[c];
      end
    end
  end

endmodule

// File: tb/tb_tc_multi.sv
// Directed self-checking bench for tc_multi (NCH=2): register map, timing, ISR/IRQ and reset behaviour.
module tb_tc_multi;
  localparam int NCH   = 2;
  localparam int CNT_W = 32;
  localparam int PSC_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int tests = 0;
  int fails = 0;

  tc_multi #(.NCH(NCH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int w, input logic [31:0] d);
    Addr = 30'(w);
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic rd(input int w, input logic [31:0] exp, input string tag);
    Addr = 30'(w);
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic irq_is(input logic exp, input string tag);
    check(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    cycles(2);
    reset = 1'b1;
    cycles(1);

    // Reset state: every word reads 0, IRQ low
    for (int w = 0; w < 32; w++) rd(w, 32'd0, $sformatf("reset_rd_w%0d", w));
    irq_is(1'b0, "reset_irq");

    // Ch0 one-shot, PRESET=5: ISR lands 7 edges after the CTRL write
    wr(1, 32'd5);
    wr(0, 32'h9);
    cycles(6);
    rd(8, 32'd0, "ch0_isr_before");
    irq_is(1'b0, "ch0_irq_before");
    cycles(1);
    rd(8, 32'd1, "ch0_isr_set");
    irq_is(1'b1, "ch0_irq_set");
    rd(2, 32'd0, "ch0_count_zero");
    cycles(1);
    rd(0, 32'h8, "ch0_en_cleared");
    rd(2, 32'd0, "ch0_count_stays");
    wr(8, 32'd1);
    rd(8, 32'd0, "ch0_isr_w1c");
    irq_is(1'b0, "ch0_irq_cleared");

    // Ch1 auto-reload, PSC=1, PRESET=3: 8-cycle period
    wr(5, 32'd3);
    wr(4, 32'h10B);
    cycles(7);
    rd(8, 32'd0, "ch1_isr_before");
    cycles(1);
    rd(8, 32'd2, "ch1_isr_first");
    irq_is(1'b1, "ch1_irq_first");
    wr(8, 32'd2);
    rd(8, 32'd0, "ch1_isr_cleared");
    cycles(6);
    rd(8, 32'd0, "ch1_isr_before2");
    cycles(1);
    rd(8, 32'd2, "ch1_isr_reset_period");
    wr(8, 32'd2);
    rd(8, 32'd0, "ch1_isr_cleared2");
    cycles(6);
    rd(8, 32'd0, "ch1_isr_before3");
    wr(8, 32'd2);
    rd(8, 32'd2, "isr_set_beats_w1c");
    wr(4, 32'h103);
    irq_is(1'b0, "im_off_irq");
    rd(8, 32'd2, "im_off_isr_kept");
    wr(4, 32'h10B);
    irq_is(1'b1, "im_on_irq");
    wr(4, 32'h0);
    cycles(3);
    wr(8, 32'd3);
    cycles(2);
    rd(8, 32'd0, "ch1_stopped");

    // Clear EN mid-count, re-enable, direct COUNT write
    wr(1, 32'd5);
    wr(0, 32'h1);
    cycles(5);
    rd(2, 32'd2, "cnt_at_2");
    wr(0, 32'h0);
    rd(2, 32'd2, "cnt_frozen_on_write");
    cycles(3);
    rd(2, 32'd2, "cnt_holds_idle");
    rd(8, 32'd0, "no_isr_when_disabled");
    wr(0, 32'h1);
    cycles(2);
    rd(2, 32'd5, "reload_preset");
    wr(2, 32'd2);
    rd(2, 32'd2, "count_write");
    cycles(1);
    rd(2, 32'd1, "count_continues");
    cycles(1);
    rd(8, 32'd1, "count_write_term");
    irq_is(1'b0, "masked_irq");
    rd(2, 32'd0, "count_term_zero");
    wr(0, 32'h8);
    irq_is(1'b1, "unmask_irq");
    wr(8, 32'd1);
    irq_is(1'b0, "unmask_irq_cleared");

    // PRESET=0 behaves like PRESET=1: ISR after 3 edges
    wr(1, 32'd0);
    wr(0, 32'h1);
    cycles(2);
    rd(8, 32'd0, "p0_isr_before");
    cycles(1);
    rd(8, 32'd1, "p0_isr_set");
    cycles(2);
    wr(8, 32'd1);
    rd(8, 32'd0, "p0_isr_cleared");

    // Reserved and unmapped words
    wr(3, 32'hFFFF_FFFF);
    rd(3, 32'd0, "reserved_word");
    wr(9, 32'hFFFF_FFFF);
    rd(9, 32'd0, "unmapped_word");
    rd(0, 32'd0, "ch0_ctrl_untouched");

`ifdef TC_CASCADE_EN
    wr(0, 32'h10);
    rd(0, 32'd0, "cas_ch0_reads_0");
    wr(5, 32'd3);
    wr(4, 32'h11);
    rd(4, 32'h11, "cas_ch1_readback");
    wr(1, 32'd2);
    wr(0, 32'h3);
    cycles(11);
    rd(8, 32'd1, "cas_ch1_before");
    cycles(1);
    rd(8, 32'd3, "cas_ch1_term");
    wr(0, 32'h0);
    wr(4, 32'h0);
    cycles(3);
    wr(8, 32'd3);
`else
    wr(4, 32'h10);
    rd(4, 32'd0, "cas_bit_reads_0");
`endif

    // Reset asserted mid-count
    wr(1, 32'd100);
    wr(0, 32'h9);
    wr(5, 32'd1);
    wr(4, 32'h9);
    cycles(8);
    rd(2, 32'd92, "midcount_value");
    irq_is(1'b1, "midcount_irq");
    reset = 1'b0;
    #1;
    irq_is(1'b0, "reset_irq_now");
    rd(2, 32'd0, "reset_count_now");
    rd(8, 32'd0, "reset_isr_now");
    cycles(2);
    reset = 1'b1;
    cycles(3);
    irq_is(1'b0, "post_reset_irq");
    rd(0, 32'd0, "post_reset_ctrl");
    rd(2, 32'd0, "post_reset_count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
- Second-generation MMIO timer/counter for the MIPS pipelined processor, on the bridge in place of the single-channel timer.
- Provides NCH independent down-counting channels. Counter width is parameterised.
- Each channel has a per-channel prescaler and selectable one-shot or auto-reload mode.
- A write-1-to-clear interrupt status register feeds one combined IRQ line to CP0.

Parameters:
- NCH, 2, number of channels (1..7).
- CNT_W, 32, PRESET/COUNT width (8..32); upper read bits return 0.
- PSC_W, 8, prescaler field width (1..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- Addr  in  30 (31:2)  word address; block decodes Addr[6:2] as local word index.
- WE  in  1  write enable, one cycle per write.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr.
- IRQ  out  1  combined interrupt request, level.

Behaviour:
- Register map (word index w):
  - For channel c: w=4c is CTRL, w=4c+1 is PRESET, w=4c+2 is COUNT, w=4c+3 is reserved (reads 0, writes ignored).
  - w=4*NCH is ISR.
  - Any other index reads 0; writes to it are ignored.
- CTRL bit fields:
  - [0] EN.
  - [2:1] MODE: 00 = one-shot; 01, 10 and 11 = auto-reload.
  - [3] IM, interrupt mask (1 = enabled).
  - [4] CAS (only with the optional feature; otherwise reads 0).
  - [8+PSC_W-1:8] PSC.
  - Other bits read 0.
- Reset (reset=0, asynchronous): all CTRL/PRESET/COUNT/ISR = 0, all prescalers = 0, all FSMs in IDLE, IRQ = 0.
- Prescaler: a channel in CNT asserts a tick when its prescaler equals PSC, then the prescaler wraps to 0. PSC=0 gives a tick every cycle; PSC=N gives a tick every N+1 cycles. The prescaler clears on entry to LOAD.
- Per-channel FSM:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds its value.
    - Else on a tick: if COUNT > 1, decrement COUNT; otherwise COUNT <= 0, set ISR[c], go to INT.
  - INT (one cycle):
    - MODE=00: clear EN, go to IDLE.
    - Any other MODE: go to LOAD (automatic reload, no IDLE cycle).
- Latency: for PRESET=P>=1, PSC=0, EN written at cycle 0, ISR[c] is set at cycle P+2 (IDLE at cycle 1, LOAD at cycle 2, then P ticks). PRESET=0 behaves like PRESET=1.
- Bus-write priority: a write to any register of channel c freezes that channel's FSM, COUNT and prescaler for that cycle; the written value takes effect. Other channels are unaffected.
- Writing COUNT in CNT loads it directly; counting continues from the new value.
- ISR: bit c is sticky.
  - Writing 1 to bit c clears it; writing 0 has no effect.
  - If a set and a W1C on the same bit occur in the same cycle, the set wins.
  - Bits at or above NCH read 0.
- IRQ = OR over c of (ISR[c] & CTRL[c].IM), registered-free (combinational from flops). Clearing IM masks IRQ but leaves ISR intact.
- Reset asserted mid-count aborts immediately with all state cleared; no IRQ glitch after release.

Optional Feature:
- TC_CASCADE_EN defined:
  - CTRL[4] CAS is writable for channels 1..NCH-1.
  - When CAS=1, channel c ticks only in cycles where channel c-1 sets its ISR bit (its terminal event); its own prescaler is ignored.
  - CAS on channel 0 reads 0.
- TC_CASCADE_EN undefined: CTRL[4] reads 0, writes are ignored, and no cascade logic is present.

Test Plan:
- Reset then read all words -> every read returns 0, IRQ=0. Assert reset mid-count -> COUNT=0, IRQ=0 at once.
- Ch0: PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> ISR[0]=1 and IRQ=1 at cycle 7 after the write. EN then reads 0 and COUNT stays 0. Write ISR=1 -> IRQ=0.
- Ch1: PRESET=3, CTRL=0x10B (PSC=1, auto-reload, IM) -> ISR[1] sets every 8 cycles in steady state (LOAD + 3 ticks x 2 + INT). Clear ISR while running -> it re-sets on the next terminal event.
- Clear EN while COUNT=2 -> next cycle FSM is IDLE and COUNT holds 2. Re-setting EN reloads PRESET.
- ISR W1C in the same cycle as a terminal event -> ISR bit stays 1. IM=0 with ISR=1 -> IRQ=0; setting IM=1 -> IRQ=1.
- With TC_CASCADE_EN: ch0 PRESET=2 auto-reload; ch1 PRESET=3, CAS=1 -> ch1 terminates after 3 ch0 terminal events. Without the macro, writing CTRL bit 4 reads back 0.
